// File: rtl/pdm_pkg.sv
// Shared widths, sample types and arithmetic helpers for the PDM-to-PCM decimator.
package pdm_pkg;

  localparam int unsigned CIC_ORDER = 3;
  localparam int unsigned CIC_W     = 20;
  localparam int unsigned OUT_SHIFT = 4;
  localparam int unsigned PCM_W     = 16;

  typedef logic signed [CIC_W-1:0] cic_t;
  typedef logic signed [PCM_W-1:0] pcm_t;

  // Drop the CIC growth bits that exceed the PCM range, then keep the low PCM_W bits.
  function automatic pcm_t trunc_pcm(input cic_t x);
    cic_t s;
    s = x >>> OUT_SHIFT;
    return pcm_t'(s[PCM_W-1:0]);
  endfunction

  function automatic pcm_t sat_pcm(input cic_t x);
    if (x > cic_t'(32767)) begin
      return 16'sh7fff;
    end
    if (x < cic_t'(-32768)) begin
      return 16'sh8000;
    end
    return pcm_t'(x[PCM_W-1:0]);
  endfunction

endpackage

// File: rtl/cic_comb_stage.sv
// One CIC comb (differentiator, delay 1) with a registered result and valid flag.
module cic_comb_stage
  import pdm_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic in_valid,
  input  cic_t in_data,
  output logic out_valid,
  output cic_t out_data
);

  cic_t prev_q, prev_d;
  cic_t out_q, out_d;
  logic valid_q, valid_d;

  always_comb begin
    prev_d  = prev_q;
    out_d   = out_q;
    valid_d = in_valid;
    if (in_valid) begin
      out_d  = in_data - prev_q;
      prev_d = in_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_q  <= '0;
      out_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      prev_q  <= prev_d;
      out_q   <= out_d;
      valid_q <= valid_d;
    end
  end

  assign out_valid = valid_q;
  assign out_data  = out_q;

endmodule

// File: rtl/pdm_decimator.sv
// PDM microphone front end: mic clock generation, 3rd-order CIC decimation, sample handshake.
// Optional DC-blocking output stage is enabled with `define PDM_DC_BLOCK_EN.
module pdm_decimator
  import pdm_pkg::*;
#(
  parameter int unsigned CLK_DIV_HALF = 16,
  parameter int unsigned DECIM        = 71
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  output logic             mic_clk,
  input  logic             pdm_in,
  output logic [PCM_W-1:0] sample,
  output logic             sample_valid,
  input  logic             sample_ready,
  output logic             overrun
);

  localparam int unsigned DIV_W = (CLK_DIV_HALF > 1) ? $clog2(CLK_DIV_HALF) : 1;
  localparam int unsigned DEC_W = (DECIM > 1) ? $clog2(DECIM) : 1;

  logic [DIV_W-1:0] div_q, div_d;
  logic [DEC_W-1:0] dec_q, dec_d;
  logic             mic_clk_q, mic_clk_d;
  logic [1:0]       sync_q, sync_d;
  cic_t             int1_q, int1_d, int2_q, int2_d, int3_q, int3_d;
  cic_t             comb_in_q, comb_in_d;
  logic             comb_in_vld_q, comb_in_vld_d;
  pcm_t             sample_q, sample_d;
  logic             sample_valid_q, sample_valid_d;
  logic             overrun_q, overrun_d;

  logic div_wrap_c, rise_c, fall_c, latch_c;
  cic_t step_c;
  logic load_c;
  pcm_t new_sample_c;

  // Mic clock divider, bit capture on the rising half, window count on the falling half.
  always_comb begin
    div_wrap_c = (div_q == DIV_W'(CLK_DIV_HALF - 1));
    rise_c     = en && div_wrap_c && !mic_clk_q;
    fall_c     = en && div_wrap_c && mic_clk_q;
    latch_c    = fall_c && (dec_q == DEC_W'(DECIM - 1));
    step_c     = sync_q[1] ? cic_t'(1) : cic_t'(-1);

    div_d         = '0;
    mic_clk_d     = 1'b0;
    dec_d         = '0;
    sync_d        = {sync_q[0], pdm_in};
    int1_d        = int1_q;
    int2_d        = int2_q;
    int3_d        = int3_q;
    comb_in_d     = comb_in_q;
    comb_in_vld_d = latch_c;

    if (en) begin
      div_d     = div_wrap_c ? '0 : div_q + DIV_W'(1);
      mic_clk_d = mic_clk_q ^ div_wrap_c;
      dec_d     = dec_q;
      if (fall_c) begin
        dec_d = latch_c ? '0 : dec_q + DEC_W'(1);
      end
    end
    if (rise_c) begin
      int1_d = int1_q + step_c;
      int2_d = int2_q + int1_d;
      int3_d = int3_q + int2_d;
    end
    if (latch_c) begin
      comb_in_d = int3_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_q         <= '0;
      dec_q         <= '0;
      mic_clk_q     <= 1'b0;
      sync_q        <= '0;
      int1_q        <= '0;
      int2_q        <= '0;
      int3_q        <= '0;
      comb_in_q     <= '0;
      comb_in_vld_q <= 1'b0;
    end else begin
      div_q         <= div_d;
      dec_q         <= dec_d;
      mic_clk_q     <= mic_clk_d;
      sync_q        <= sync_d;
      int1_q        <= int1_d;
      int2_q        <= int2_d;
      int3_q        <= int3_d;
      comb_in_q     <= comb_in_d;
      comb_in_vld_q <= comb_in_vld_d;
    end
  end

  cic_t comb_data [0:CIC_ORDER];
  logic comb_vld  [0:CIC_ORDER];

  assign comb_data[0] = comb_in_q;
  assign comb_vld[0]  = comb_in_vld_q;

  for (genvar i = 0; i < CIC_ORDER; i++) begin : g_comb
    cic_comb_stage u_stage (
      .clk      (clk),
      .rst_n    (rst_n),
      .in_valid (comb_vld[i]),
      .in_data  (comb_data[i]),
      .out_valid(comb_vld[i+1]),
      .out_data (comb_data[i+1])
    );
  end

`ifdef PDM_DC_BLOCK_EN
  cic_t dc_x_q, dc_x_d, dc_y_q, dc_y_d;
  pcm_t dc_out_q, dc_out_d;
  logic dc_vld_q, dc_vld_d;
  cic_t dc_in_c, dc_acc_c;

  // Leaky differentiator: pole at 1 - 2^-8 removes the CIC's DC gain.
  always_comb begin
    dc_in_c  = cic_t'(trunc_pcm(comb_data[CIC_ORDER]));
    dc_acc_c = dc_in_c - dc_x_q + dc_y_q - (dc_y_q >>> 8);
    dc_x_d   = dc_x_q;
    dc_y_d   = dc_y_q;
    dc_out_d = dc_out_q;
    dc_vld_d = comb_vld[CIC_ORDER];
    if (comb_vld[CIC_ORDER]) begin
      dc_x_d   = dc_in_c;
      dc_y_d   = dc_acc_c;
      dc_out_d = sat_pcm(dc_acc_c);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dc_x_q   <= '0;
      dc_y_q   <= '0;
      dc_out_q <= '0;
      dc_vld_q <= 1'b0;
    end else begin
      dc_x_q   <= dc_x_d;
      dc_y_q   <= dc_y_d;
      dc_out_q <= dc_out_d;
      dc_vld_q <= dc_vld_d;
    end
  end

  assign load_c       = dc_vld_q;
  assign new_sample_c = dc_out_q;
`else
  assign load_c       = comb_vld[CIC_ORDER];
  assign new_sample_c = trunc_pcm(comb_data[CIC_ORDER]);
`endif

  // Output holding register: a new sample always wins; overwriting unread data flags overrun.
  always_comb begin
    sample_d       = load_c ? new_sample_c : sample_q;
    sample_valid_d = load_c || (sample_valid_q && !sample_ready);
    overrun_d      = load_c && sample_valid_q && !sample_ready;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sample_q       <= '0;
      sample_valid_q <= 1'b0;
      overrun_q      <= 1'b0;
    end else begin
      sample_q       <= sample_d;
      sample_valid_q <= sample_valid_d;
      overrun_q      <= overrun_d;
    end
  end

  assign mic_clk      = mic_clk_q;
  assign sample       = sample_q;
  assign sample_valid = sample_valid_q;
  assign overrun      = overrun_q;

endmodule

// File: tb/tb_pdm_decimator.sv
// Randomized bench for pdm_decimator against a closed-form CIC model (binomial-weighted bit sums).
module tb_pdm_decimator;

  localparam int H   = 16;
  localparam int DEC = 71;
  localparam int PER = 2 * H * DEC;
`ifdef PDM_DC_BLOCK_EN
  localparam int LAT = 5;
`else
  localparam int LAT = 4;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic en = 1'b0;
  logic pdm_in = 1'b0;
  logic sample_ready = 1'b0;
  logic mic_clk, sample_valid, overrun;
  logic [15:0] sample;

  pdm_decimator #(.CLK_DIV_HALF(H), .DECIM(DEC)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .en          (en),
    .mic_clk     (mic_clk),
    .pdm_in      (pdm_in),
    .sample      (sample),
    .sample_valid(sample_valid),
    .sample_ready(sample_ready),
    .overrun     (overrun)
  );

  always #5 clk = ~clk;

  typedef struct { int due; logic signed [15:0] val; } pend_t;

  int n_cmp = 0;
  int n_bad = 0;
  int bits[$];
  int latches[$];
  pend_t pend[$];
  int cyc = 0, m = 0, wcnt = 0, mode = 1, loads = 0;
  logic alt = 1'b0;
  logic exp_mic = 1'b0, exp_valid = 1'b0, exp_ov = 1'b0;
  logic signed [15:0] exp_sample = '0;
  logic signed [19:0] dc_x = '0, dc_y = '0;
  logic signed [15:0] model_first = '0;
  logic model_first_set = 1'b0;
  int first_valid = -1, xfers = 0, ovs = 0, mic_hi = 0;
  int rises[$];
  logic prev_valid = 1'b0;
  logic signed [15:0] last_xfer = '0;

  // Third running sum of the first n bits: sum of C(n-j+1, 2) * bit[j].
  function automatic longint i3(int n);
    longint s = 0;
    for (int j = 0; j < n; j++) s += longint'((n - j) * (n - j + 1) / 2) * longint'(bits[j]);
    return s;
  endfunction

  function automatic logic signed [15:0] cic_out();
    int k = latches.size();
    longint v;
    logic signed [19:0] v20, sh;
    v = i3(latches[k-1]);
    if (k >= 2) v -= 3 * i3(latches[k-2]);
    if (k >= 3) v += 3 * i3(latches[k-3]);
    if (k >= 4) v -= i3(latches[k-4]);
    v20 = v[19:0];
    sh = v20 >>> 4;
    return sh[15:0];
  endfunction

  function automatic logic signed [15:0] post(input logic signed [15:0] t);
`ifdef PDM_DC_BLOCK_EN
    logic signed [19:0] x, y;
    x = 20'(t);
    y = x - dc_x + dc_y - (dc_y >>> 8);
    dc_x = x;
    dc_y = y;
    if (y > 20'sd32767) return 16'sh7fff;
    if (y < -20'sd32768) return 16'sh8000;
    return y[15:0];
`else
    return t;
`endif
  endfunction

  task automatic model_reset();
    bits.delete(); latches.delete(); pend.delete();
    m = 0; wcnt = 0;
    exp_mic = 0; exp_valid = 0; exp_ov = 0; exp_sample = '0;
    dc_x = '0; dc_y = '0;
  endtask

  // Advance the model across one clock edge using the inputs of the cycle just ended.
  task automatic model_step();
    cyc++;
    if (!rst_n) return;
    if (en && (m % (2 * H)) == H - 1) bits.push_back(pdm_in ? 1 : -1);
    if (en && (m % (2 * H)) == 2 * H - 1) begin
      wcnt++;
      if (wcnt == DEC) begin
        wcnt = 0;
        latches.push_back(bits.size());
        pend.push_back('{due: cyc + LAT, val: post(cic_out())});
      end
    end
    if (!en) wcnt = 0;
    m = en ? m + 1 : 0;
    exp_ov = 1'b0;
    if (pend.size() > 0 && pend[0].due == cyc) begin
      exp_ov = exp_valid && !sample_ready;
      exp_sample = pend[0].val;
      exp_valid = 1'b1;
      if (!model_first_set) begin model_first = pend[0].val; model_first_set = 1'b1; end
      void'(pend.pop_front());
      loads++;
    end else if (exp_valid && sample_ready) begin
      exp_valid = 1'b0;
    end
    exp_mic = ((m / H) % 2) == 1;
  endtask

  task automatic chk1(input string name, input logic got, input logic want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s cyc=%0d: got %b, required %b", name, cyc, got, want);
    end
  endtask

  task automatic check(input string name, input int got, input int want);
    n_cmp++;
    if (got != want) begin
      n_bad++;
      $display("FAIL %s: got %0d, required %0d", name, got, want);
    end
  endtask

  task automatic compare();
    chk1("mic_clk", mic_clk, exp_mic);
    chk1("sample_valid", sample_valid, exp_valid);
    chk1("overrun", overrun, exp_ov);
    n_cmp++;
    if (sample !== exp_sample) begin
      n_bad++;
      $display("FAIL sample cyc=%0d: got %0d, required %0d", cyc, $signed(sample), exp_sample);
    end
    if (!rst_n) first_valid = -1;
    else if (sample_valid && first_valid < 0) first_valid = cyc;
    if (sample_valid && !prev_valid) rises.push_back(cyc);
    prev_valid = sample_valid;
    if (sample_valid && sample_ready) begin xfers++; last_xfer = sample; end
    if (overrun) ovs++;
    if (mic_clk) mic_hi++;
  endtask

  task automatic tick();
    if (!rst_n) model_reset();
    if (rst_n && en && (m % (2 * H)) == 0) begin
      case (mode)
        1: pdm_in = 1'b1;
        2: pdm_in = 1'b0;
        3: begin alt = ~alt; pdm_in = alt; end
        default: pdm_in = 1'($urandom % 2);
      endcase
    end
    @(negedge clk);
    compare();
    @(posedge clk);
    #1;
    model_step();
  endtask

  task automatic wait_xfers(input int n);
    int target = xfers + n;
    int t = 0;
    while (xfers < target && t < PER * (n + 2)) begin tick(); t++; end
    if (xfers < target) check("xfer_timeout", xfers, target);
  endtask

  task automatic wait_loads(input int n);
    int target = loads + n;
    int t = 0;
    while (loads < target && t < PER * (n + 2)) begin tick(); t++; end
    if (loads < target) check("load_timeout", loads, target);
  endtask

  initial begin
    int rel, o0, h0, r0, e0, a, t;
    rst_n = 1'b0; en = 1'b1; sample_ready = 1'b1; mode = 1;
    repeat (3) tick();
    check("reset_sample", int'(sample), 0);
    check("reset_valid", int'(sample_valid), 0);
    rst_n = 1'b1; rel = cyc;

    // Steady ones: first window is 71 fresh +1 bits, later windows the full CIC gain.
    wait_xfers(5);
    check("first_valid_latency", first_valid - rel, PER + LAT);
`ifndef PDM_DC_BLOCK_EN
    check("model_first_ones", int'(model_first), 3887);
    check("steady_ones", int'(last_xfer), 22369);
`endif
    mode = 2;
    wait_xfers(5);
`ifndef PDM_DC_BLOCK_EN
    check("steady_zeros", int'(last_xfer), -22370);
`endif
    mode = 3;
    wait_xfers(5);
`ifndef PDM_DC_BLOCK_EN
    a = int'(last_xfer);
    n_cmp++;
    if (a < -1 || a > 1) begin
      n_bad++;
      $display("FAIL alt_near_zero: got %0d, required -1..1", a);
    end
`endif

    // Random bits with random backpressure; the per-cycle compare covers overruns.
    mode = 0;
    o0 = loads;
    t = 0;
    while (loads < o0 + 4 && t < PER * 6) begin
      sample_ready = ($urandom % 3) != 0;
      tick();
      t++;
    end
    if (loads < o0 + 4) check("random_timeout", loads, o0 + 4);

    // Backpressure across two sample periods, then ready coinciding with a load.
    sample_ready = 1'b1;
    wait_loads(1);
    repeat (5) tick();
    o0 = ovs;
    sample_ready = 1'b0;
    wait_loads(2);
    repeat (5) tick();
    check("bp_overrun_once", ovs - o0, 1);
    check("bp_valid_held", int'(sample_valid), 1);
    check("bp_newest_sample", int'($signed(sample)), int'(exp_sample));
    t = 0;
    while (!(pend.size() > 0 && pend[0].due == cyc + 1) && t < PER * 2) begin tick(); t++; end
    o0 = ovs;
    sample_ready = 1'b1;
    tick();
    check("coincide_valid", int'(sample_valid), 1);
    check("coincide_no_overrun", int'(overrun), 0);
    repeat (3) tick();
    check("coincide_ovs", ovs - o0, 0);

    // Enable gating: clock parks low, no fresh samples, cadence restarts cleanly.
    wait_loads(1);
    repeat (10) tick();
    en = 1'b0;
    h0 = mic_hi; r0 = rises.size();
    repeat (10000) tick();
    check("gated_mic_hi", mic_hi - h0, 0);
    check("gated_new_valid", rises.size() - r0, 0);
    en = 1'b1; e0 = cyc;
    t = 0;
    while (rises.size() < r0 + 3 && t < PER * 5) begin tick(); t++; end
    if (rises.size() >= r0 + 3) begin
      check("reenable_first", rises[r0] - e0, PER + LAT);
      check("cadence_1", rises[r0+1] - rises[r0], PER);
      check("cadence_2", rises[r0+2] - rises[r0+1], PER);
    end else begin
      check("reenable_timeout", rises.size(), r0 + 3);
    end

    // Reset in the middle of a window.
    repeat (1000) tick();
    rst_n = 1'b0;
    #1;
    check("midrst_mic_clk", int'(mic_clk), 0);
    check("midrst_sample", int'(sample), 0);
    check("midrst_valid", int'(sample_valid), 0);
    check("midrst_overrun", int'(overrun), 0);
    tick();
    tick();
    rst_n = 1'b1; rel = cyc;
    wait_xfers(1);
    check("midrst_first_valid", first_valid - rel, PER + LAT);
    repeat (5) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
